// File: rtl/stopwatch_display.sv
// MM:SS stopwatch driven by the divider's 1 Hz wave, with a registered, multiplexed active-low 7-segment output.
// Optional macro LZ_BLANK_EN blanks a leading-zero minute-tens digit.
module stopwatch_display #(
  parameter int MAX_MINUTES = 59,
  parameter int DP_DIGIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sec_clk,
  input  logic [1:0]  scan_sel,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [15:0] bcd,
  output logic        running,
  output logic        full,
  output logic [7:0]  segs,
  output logic [3:0]  digit_en
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FULL} state_t;

  localparam logic [3:0] MAX_TENS = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MINUTES % 10);

  state_t           state, state_next;
  logic [3:0][3:0]  cnt, cnt_next, cnt_inc;
  logic             sec_clk_d;
  logic             tick;
  logic             at_max;
  logic [3:0]       digit;
  logic [6:0]       pattern;
  logic [7:0]       segs_reg;
  logic [3:0]       digit_en_reg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // sec_clk_d resets high so a sec_clk already high at release is not a tick.
  assign tick   = sec_clk & ~sec_clk_d;
  assign at_max = (cnt[3] == MAX_TENS) && (cnt[2] == MAX_ONES) &&
                  (cnt[1] == 4'd5) && (cnt[0] == 4'd9);

  // Ripple-carry BCD increment; min_tens never overflows because the count saturates first.
  always_comb begin
    cnt_inc = cnt;
    if (cnt[0] == 4'd9) begin
      cnt_inc[0] = 4'd0;
      if (cnt[1] == 4'd5) begin
        cnt_inc[1] = 4'd0;
        if (cnt[2] == 4'd9) begin
          cnt_inc[2] = 4'd0;
          cnt_inc[3] = cnt[3] + 4'd1;
        end else begin
          cnt_inc[2] = cnt[2] + 4'd1;
        end
      end else begin
        cnt_inc[1] = cnt[1] + 4'd1;
      end
    end else begin
      cnt_inc[0] = cnt[0] + 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (btn_clear) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE:  if (btn_start) state_next = RUN;
        RUN: begin
          if (tick && at_max && !btn_start) begin
            state_next = FULL;
          end else begin
            if (tick && !at_max) cnt_next = cnt_inc;
            if (btn_start) state_next = PAUSE;
          end
        end
        PAUSE: if (btn_start) state_next = RUN;
        FULL:  ;
      endcase
    end
  end

  always_comb begin
    digit   = cnt[scan_sel];
    pattern = seg7(digit);
`ifdef LZ_BLANK_EN
    if (scan_sel == 2'd3 && cnt[3] == 4'd0) pattern = 7'b1111111;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      sec_clk_d    <= 1'b1;
      segs_reg     <= 8'hFF;
      digit_en_reg <= 4'hF;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      sec_clk_d    <= sec_clk;
      segs_reg     <= {pattern, (int'(scan_sel) == DP_DIGIT) ? 1'b0 : 1'b1};
      digit_en_reg <= ~(4'b0001 << scan_sel);
    end
  end

  assign bcd      = cnt;
  assign running  = (state == RUN);
  assign full     = (state == FULL);
  assign segs     = segs_reg;
  assign digit_en = digit_en_reg;

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: two instances (MAX_MINUTES 59 and 1) share random and directed stimulus.
// A seconds-count reference model pushes expected outputs; a negedge monitor pops and compares.
module tb_stopwatch_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sec_clk, btn_start, btn_clear;
  logic [1:0]  scan_sel;
  logic [15:0] bcd_o [2];
  logic        running_o [2];
  logic        full_o [2];
  logic [7:0]  segs_o [2];
  logic [3:0]  den_o [2];

  stopwatch_display #(.MAX_MINUTES(59), .DP_DIGIT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .sec_clk(sec_clk), .scan_sel(scan_sel),
    .btn_start(btn_start), .btn_clear(btn_clear), .bcd(bcd_o[0]),
    .running(running_o[0]), .full(full_o[0]), .segs(segs_o[0]), .digit_en(den_o[0]));

  stopwatch_display #(.MAX_MINUTES(1), .DP_DIGIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sec_clk(sec_clk), .scan_sel(scan_sel),
    .btn_start(btn_start), .btn_clear(btn_clear), .bcd(bcd_o[1]),
    .running(running_o[1]), .full(full_o[1]), .segs(segs_o[1]), .digit_en(den_o[1]));

  typedef struct packed {
    logic [15:0] bcd;
    logic        running;
    logic        full;
    logic [7:0]  segs;
    logic [3:0]  den;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model: elapsed seconds plus a mode (0 idle, 1 run, 2 pause, 3 full).
  int   m_mode [2];
  int   m_secs [2];
  int   m_max  [2];
  bit   m_prev;
  logic [6:0] seg_tab [10];

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() >= 2) begin
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("bcd%0d", i),     32'(bcd_o[i]),     32'(e.bcd));
        chk($sformatf("running%0d", i), 32'(running_o[i]), 32'(e.running));
        chk($sformatf("full%0d", i),    32'(full_o[i]),    32'(e.full));
        chk($sformatf("segs%0d", i),    32'(segs_o[i]),    32'(e.segs));
        chk($sformatf("digit_en%0d", i),32'(den_o[i]),     32'(e.den));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_secs[i] = 0;
    end
    m_prev = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict outputs after the next rising edge.
  task automatic step(input bit st, input bit cl, input bit sc, input logic [1:0] ss, input bit rst);
    bit tick;
    @(negedge clk);
    #1;
    rst_n = rst; btn_start = st; btn_clear = cl; sec_clk = sc; scan_sel = ss;
    tick = sc && !m_prev;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      logic [15:0] old;
      logic [3:0]  d;
      logic [6:0]  pat;
      if (!rst) begin
        m_mode[i] = 0;
        m_secs[i] = 0;
        e = '{bcd: 16'h0, running: 1'b0, full: 1'b0, segs: 8'hFF, den: 4'hF};
      end else begin
        old = to_bcd(m_secs[i]);
        d   = old[ss*4 +: 4];
        pat = seg_tab[d];
`ifdef LZ_BLANK_EN
        if (ss == 2'd3 && old[15:12] == 4'd0) pat = 7'b1111111;
`endif
        if (cl) begin
          m_mode[i] = 0;
          m_secs[i] = 0;
        end else begin
          case (m_mode[i])
            0: if (st) m_mode[i] = 1;
            1: begin
              if (tick && m_secs[i] == m_max[i] * 60 + 59 && !st) begin
                m_mode[i] = 3;
              end else begin
                if (tick && m_secs[i] < m_max[i] * 60 + 59) m_secs[i]++;
                if (st) m_mode[i] = 2;
              end
            end
            2: if (st) m_mode[i] = 1;
            default: ;
          endcase
        end
        e.bcd     = to_bcd(m_secs[i]);
        e.running = (m_mode[i] == 1);
        e.full    = (m_mode[i] == 3);
        e.segs    = {pat, (ss == 2'd2) ? 1'b0 : 1'b1};
        e.den     = ~(4'b0001 << ss);
      end
      sb.push_back(e);
    end
    m_prev = rst ? sc : 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b1);
      step(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    m_max[0] = 59;
    m_max[1] = 1;
    model_reset();
    rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; sec_clk = 1'b0; scan_sel = 2'd0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    ticks(75);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    repeat (600)
      step($urandom_range(0, 11) == 0, $urandom_range(0, 79) == 0,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1);

    // start coincident with a tick, in RUN and then in PAUSE
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    ticks(7);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    ticks(3);
    step(1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);

    // clear, start and tick together from 00:30 RUN
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    ticks(30);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1);

    // 05:00 on minute tens; the MAX_MINUTES=1 instance saturates and ignores start
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    ticks(300);
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
    ticks(454);
    step(1'b0, 1'b0, 1'b0, 2'd2, 1'b1);

    // asynchronous reset at 12:34, checked with no clock edge in between
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_bcd%0d", i),     32'(bcd_o[i]),     32'h0);
      chk($sformatf("async_running%0d", i), 32'(running_o[i]), 32'h0);
      chk($sformatf("async_full%0d", i),    32'(full_o[i]),    32'h0);
      chk($sformatf("async_segs%0d", i),    32'(segs_o[i]),    32'hFF);
      chk($sformatf("async_digit_en%0d", i),32'(den_o[i]),     32'hF);
    end
    model_reset();
    repeat (2) step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    ticks(5);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    ticks(3);

    repeat (3) @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
